// File: rtl/mole_scheduler_pkg.sv
// Shared types, constants and level-dependent helper functions for the
// whack-a-mole slot scheduler.
package mole_pkg;

  localparam int LED_NUM     = 18;
  localparam int MAX_ACTIVE  = 4;
  localparam int BASE_ON_MS  = 1000;
  localparam int ON_MS_STEP  = 100;
  localparam int MIN_ON_MS   = 300;
  localparam int GAP_MS      = 250;
  localparam int SPAWN_RETRY = 8;

  localparam int CNT_W   = 11;
  localparam int IDX_W   = $clog2(LED_NUM);
  localparam int HCNT_W  = $clog2(MAX_ACTIVE + 1);
  localparam int SLOT_W  = $clog2(MAX_ACTIVE);
  localparam int GAP_W   = $clog2(GAP_MS);
  localparam int RETRY_W = $clog2(SPAWN_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    SPAWN = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
  } slot_t;

  // Mole lifetime in ms; computed in 32-bit signed so high levels clamp
  // to the floor instead of wrapping.
  function automatic logic [CNT_W-1:0] on_time_ms(input logic [3:0] level);
    int t;
    t = BASE_ON_MS - ON_MS_STEP * int'(level);
    t = (t < MIN_ON_MS) ? MIN_ON_MS : t;
    return CNT_W'(t);
  endfunction

  // Number of moles allowed at once: one more every four levels.
  function automatic logic [HCNT_W-1:0] allow_count(input logic [3:0] level);
    int a;
    a = 1 + int'(level) / 4;
    a = (a > MAX_ACTIVE) ? MAX_ACTIVE : a;
    return HCNT_W'(a);
  endfunction

  // Population count over the per-slot flag vector.
  function automatic logic [HCNT_W-1:0] popcount_slots(input logic [MAX_ACTIVE-1:0] v);
    logic [HCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_ACTIVE; i++) begin
      n = n + HCNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Bus between the game logic (master) and the mole scheduler (slave).
interface mole_if;
  import mole_pkg::*;

  logic                game_active;
  logic                ms_tick;
  logic [3:0]          level;
  logic [IDX_W-1:0]    random_value;
  logic [LED_NUM-1:0]  hit_mask;
  logic [LED_NUM-1:0]  led_on;
  logic [HCNT_W-1:0]   hit_cnt;
  logic [HCNT_W-1:0]   miss_cnt;
  logic                wrong_pulse;
  logic                spawn_pulse;

  modport master (
    output game_active, ms_tick, level, random_value, hit_mask,
    input  led_on, hit_cnt, miss_cnt, wrong_pulse, spawn_pulse
  );

  modport slave (
    input  game_active, ms_tick, level, random_value, hit_mask,
    output led_on, hit_cnt, miss_cnt, wrong_pulse, spawn_pulse
  );
endinterface

// File: rtl/mole_scheduler_slot.sv
// One mole slot: holds a lit LED index and its remaining lifetime, and
// reports a hit or an expiry from its registered state.
module mole_slot
  import mole_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic [IDX_W-1:0]   load_idx_i,
  input  logic [CNT_W-1:0]   load_cnt_i,
  input  logic               ms_tick_i,
  input  logic [LED_NUM-1:0] hit_mask_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               hit_o,
  output logic               expire_o
);

  slot_t slot_q;
  slot_t slot_d;

  // A hit takes priority over an expiry falling in the same cycle.
  assign hit_o    = slot_q.valid & hit_mask_i[slot_q.idx];
  assign expire_o = slot_q.valid & ms_tick_i & (slot_q.cnt == CNT_W'(1)) & ~hit_o;
  assign valid_o  = slot_q.valid;
  assign idx_o    = slot_q.idx;

  // Next slot contents: flush, load, retire or count down.
  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d = '0;
    end else if (load_i) begin
      slot_d = '{valid: 1'b1, idx: load_idx_i, cnt: load_cnt_i};
    end else if (hit_o | expire_o) begin
      slot_d.valid = 1'b0;
    end else if (slot_q.valid & ms_tick_i) begin
      slot_d.cnt = slot_q.cnt - CNT_W'(1);
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Slot-based mole scheduler: paces spawn attempts, picks the lowest free
// slot, and turns slot hits/expiries into registered LED and score pulses.
module mole_scheduler
  import mole_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mole_if.slave bus
);

  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_MS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(SPAWN_RETRY - 1);

  logic [MAX_ACTIVE-1:0] slot_valid_s;
  logic [MAX_ACTIVE-1:0] slot_hit_s;
  logic [MAX_ACTIVE-1:0] slot_expire_s;
  logic [MAX_ACTIVE-1:0] slot_load_s;
  logic [IDX_W-1:0]      slot_idx_s [MAX_ACTIVE];
  logic [CNT_W-1:0]      on_ms_s;

  logic [HCNT_W-1:0]     active_cnt_s;
  logic                  room_s;
  logic                  rv_free_s;
  logic [SLOT_W-1:0]     free_slot_s;
  logic                  free_found_s;
  logic                  spawn_go_s;
  logic [LED_NUM-1:0]    led_d;

  sched_state_t          state_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [RETRY_W-1:0]    retry_q;
  logic [LED_NUM-1:0]    led_on_q;
  logic [HCNT_W-1:0]     hit_cnt_q;
  logic [HCNT_W-1:0]     miss_cnt_q;
  logic                  wrong_q;
  logic                  spawn_q;

  assign on_ms_s = on_time_ms(bus.level);

  for (genvar g = 0; g < MAX_ACTIVE; g++) begin : g_slot
    mole_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (~bus.game_active),
      .load_i     (slot_load_s[g]),
      .load_idx_i (bus.random_value),
      .load_cnt_i (on_ms_s),
      .ms_tick_i  (bus.ms_tick),
      .hit_mask_i (bus.hit_mask),
      .valid_o    (slot_valid_s[g]),
      .idx_o      (slot_idx_s[g]),
      .hit_o      (slot_hit_s[g]),
      .expire_o   (slot_expire_s[g])
    );
  end

  // Spawn decision against registered state: room left, usable LED, lowest free slot.
  always_comb begin
    active_cnt_s = popcount_slots(slot_valid_s);
    room_s       = active_cnt_s < allow_count(bus.level);
    rv_free_s    = 1'b0;
    if (bus.random_value < IDX_W'(LED_NUM)) begin
      rv_free_s = ~led_on_q[bus.random_value];
    end else begin
      rv_free_s = 1'b0;
    end
    free_slot_s  = '0;
    free_found_s = 1'b0;
    for (int i = MAX_ACTIVE - 1; i >= 0; i--) begin
      if (!slot_valid_s[i]) begin
        free_slot_s  = SLOT_W'(i);
        free_found_s = 1'b1;
      end else begin
        free_found_s = free_found_s;
      end
    end
    spawn_go_s  = (state_q == SPAWN) & bus.game_active & room_s & rv_free_s & free_found_s;
    slot_load_s = spawn_go_s ? (MAX_ACTIVE'(1) << free_slot_s) : '0;
  end

  // LED field as it will stand after this edge, so led_on tracks the slots exactly.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < MAX_ACTIVE; i++) begin
      if (slot_load_s[i]) begin
        led_d[bus.random_value] = 1'b1;
      end else if (slot_valid_s[i] & ~slot_hit_s[i] & ~slot_expire_s[i]) begin
        led_d[slot_idx_s[i]] = 1'b1;
      end else begin
        led_d = led_d;
      end
    end
  end

  // Scheduler FSM with its counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset || !bus.game_active) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      retry_q    <= '0;
      led_on_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wrong_q    <= 1'b0;
      spawn_q    <= 1'b0;
    end else begin
      led_on_q   <= led_d;
      hit_cnt_q  <= popcount_slots(slot_hit_s);
      miss_cnt_q <= popcount_slots(slot_expire_s);
      wrong_q    <= |(bus.hit_mask & ~led_on_q);
      spawn_q    <= spawn_go_s;
      case (state_q)
        IDLE: begin
          state_q   <= GAP;
          gap_cnt_q <= '0;
        end
        GAP: begin
          if (bus.ms_tick) begin
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= SPAWN;
              retry_q <= '0;
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
          end
        end
        SPAWN: begin
          if (!room_s || spawn_go_s) begin
            state_q   <= GAP;
            gap_cnt_q <= '0;
          end else if (retry_q == RETRY_LAST) begin
            state_q   <= GAP;
            gap_cnt_q <= '0;
          end else begin
            retry_q <= retry_q + RETRY_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          gap_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.led_on      = led_on_q;
  assign bus.hit_cnt     = hit_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;
  assign bus.wrong_pulse = wrong_q;
  assign bus.spawn_pulse = spawn_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler against a queue-of-moles reference model.
module tb_mole_scheduler;
  import mole_pkg::*;

  logic clk = 1'b0;
  logic reset;
  mole_if bus ();

  mole_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: live moles as {led, ticks left}, no slot identity
  typedef struct {
    int led;
    int left;
  } mole_t;
  mole_t moles[$];
  bit    m_busy;
  bit    m_in_gap;
  int    m_gap;
  int    m_tries;
  logic [LED_NUM-1:0] e_led;
  int    e_hit, e_miss;
  bit    e_wrong, e_spawn;
  int    cur_lvl;
  int    cyc_rv;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int life_of(int lvl);
    int t;
    t = 1000 - 100 * lvl;
    return (t < 300) ? 300 : t;
  endfunction

  function automatic int allow_of(int lvl);
    int a;
    a = 1 + lvl / 4;
    return (a > 4) ? 4 : a;
  endfunction

  function automatic logic [LED_NUM-1:0] lit_now();
    logic [LED_NUM-1:0] m;
    m = '0;
    foreach (moles[i]) m[moles[i].led] = 1'b1;
    return m;
  endfunction

  task automatic model_step(input bit rst, input bit ga, input bit tick, input int lvl,
                            input int rv, input logic [LED_NUM-1:0] hm);
    logic [LED_NUM-1:0] lit;
    mole_t nq[$];
    mole_t m;
    bit do_spawn;
    if (rst || !ga) begin
      moles.delete();
      m_busy = 1'b0; e_led = '0; e_hit = 0; e_miss = 0; e_wrong = 1'b0; e_spawn = 1'b0;
      return;
    end
    lit = lit_now();
    e_wrong = |(hm & ~lit);
    do_spawn = 1'b0;
    if (!m_busy) begin
      m_busy = 1'b1; m_in_gap = 1'b1; m_gap = 0;
    end else if (m_in_gap) begin
      if (tick) begin
        m_gap++;
        if (m_gap == GAP_MS) begin m_in_gap = 1'b0; m_tries = 0; end
      end
    end else begin
      if (moles.size() >= allow_of(lvl)) begin
        m_in_gap = 1'b1; m_gap = 0;
      end else if (rv >= LED_NUM || lit[rv]) begin
        m_tries++;
        if (m_tries == SPAWN_RETRY) begin m_in_gap = 1'b1; m_gap = 0; end
      end else begin
        do_spawn = 1'b1; m_in_gap = 1'b1; m_gap = 0;
      end
    end
    e_hit = 0; e_miss = 0;
    foreach (moles[i]) begin
      if (hm[moles[i].led]) e_hit++;
      else if (tick && moles[i].left == 1) e_miss++;
      else begin
        m = moles[i];
        if (tick) m.left--;
        nq.push_back(m);
      end
    end
    if (do_spawn) begin
      m.led = rv; m.left = life_of(lvl);
      nq.push_back(m);
    end
    moles = nq;
    e_spawn = do_spawn;
    e_led = lit_now();
  endtask

  // rv_mode: >=0 fixed value, -1 random 0..31, -2 cycles 1..5; lvl<0: random drift
  // drop/rst in permille per cycle, tick/hit in percent
  task automatic run(input int n, input int lvl, input int rv_mode, input int tick_pct,
                     input int hit_pct, input int drop_pm, input int rst_pm);
    bit r, ga, tk;
    int rv, k, j;
    logic [LED_NUM-1:0] hm;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_val("led_on", 32'(bus.led_on), 32'(e_led));
      check_val("hit_cnt", 32'(bus.hit_cnt), 32'(e_hit));
      check_val("miss_cnt", 32'(bus.miss_cnt), 32'(e_miss));
      check_val("wrong_pulse", 32'(bus.wrong_pulse), 32'(e_wrong));
      check_val("spawn_pulse", 32'(bus.spawn_pulse), 32'(e_spawn));
      r  = ($urandom_range(0, 999) < rst_pm);
      ga = !($urandom_range(0, 999) < drop_pm);
      if (lvl >= 0) cur_lvl = lvl;
      else if ($urandom_range(0, 99) == 0) cur_lvl = $urandom_range(0, 15);
      if (rv_mode >= 0) rv = rv_mode;
      else if (rv_mode == -1) rv = $urandom_range(0, 31);
      else begin cyc_rv = (cyc_rv % 5) + 1; rv = cyc_rv; end
      tk = ($urandom_range(0, 99) < tick_pct);
      hm = '0;
      if ($urandom_range(0, 99) < hit_pct) begin
        k = $urandom_range(0, 3);
        if (moles.size() > 0 && k < 3) begin
          j = $urandom_range(0, moles.size() - 1);
          foreach (moles[q]) if (tk && moles[q].left == 1) j = q;
          hm[moles[j].led] = 1'b1;
          if (k == 2) hm[$urandom_range(0, LED_NUM - 1)] = 1'b1;
        end else begin
          hm[$urandom_range(0, LED_NUM - 1)] = 1'b1;
        end
      end
      reset            = r;
      bus.game_active  = ga;
      bus.ms_tick      = tk;
      bus.level        = 4'(cur_lvl);
      bus.random_value = IDX_W'(rv);
      bus.hit_mask     = hm;
      model_step(r, ga, tk, cur_lvl, rv, hm);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.game_active = 1'b0; bus.ms_tick = 1'b0; bus.level = 4'd0;
    bus.random_value = '0; bus.hit_mask = '0;
    cur_lvl = 0; cyc_rv = 0;
    model_step(1'b1, 1'b0, 1'b0, 0, 0, '0);
    run(3, 0, 5, 100, 0, 0, 1000);      // reset state
    run(1300, 0, 5, 100, 0, 0, 0);      // single mole on LED 5, full 1000-tick life
    run(1600, 4, -2, 100, 0, 0, 0);     // allow=2 cap with cycling LEDs
    run(1500, 8, -1, 100, 25, 0, 0);    // hits, wrong hits, hit-vs-expiry races
    run(600, 0, 20, 100, 0, 0, 0);      // out-of-range LED: retries only
    run(3000, 15, -1, 100, 5, 2, 0);    // floor lifetime, game_active drops
    run(15000, -1, -1, 60, 10, 1, 1);   // everything random
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
